// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate and retire, two
// out-of-order writeback ports, operand lookup, mispredict flush.
module rob_param #(
  parameter  int DEPTH = 16,
  parameter  int XLEN  = 32,
  localparam int TAGW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [TAGW-1:0] alloc_tag,
  input  logic [1:0]      alloc_kind,
  input  logic [4:0]      alloc_rd,
  input  logic            alloc_done,
  input  logic [XLEN-1:0] alloc_val,
  input  logic            alloc_pred,
  input  logic [XLEN-1:0] alloc_alt_pc,
  input  logic            wb0_valid,
  input  logic [TAGW-1:0] wb0_tag,
  input  logic [XLEN-1:0] wb0_val,
  input  logic            wb0_taken,
  input  logic [XLEN-1:0] wb0_target,
  input  logic            wb1_valid,
  input  logic [TAGW-1:0] wb1_tag,
  input  logic [XLEN-1:0] wb1_val,
  input  logic [TAGW-1:0] q1_tag,
  input  logic [TAGW-1:0] q2_tag,
  output logic            q1_ready,
  output logic            q2_ready,
  output logic [XLEN-1:0] q1_val,
  output logic [XLEN-1:0] q2_val,
  output logic            cm_valid,
  output logic [4:0]      cm_rd,
  output logic [XLEN-1:0] cm_val,
  output logic [TAGW-1:0] cm_tag,
  output logic            st_commit,
  output logic [TAGW-1:0] st_tag,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc,
  output logic [TAGW:0]   count
);

  localparam logic [TAGW:0] FULL = (TAGW+1)'(DEPTH);

  logic [DEPTH-1:0] vld_q, rdy_q;
  logic [1:0]       kind_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic             pred_q [DEPTH];
  logic             tkn_q  [DEPTH];
  logic [XLEN-1:0]  alt_q  [DEPTH];
  logic [XLEN-1:0]  tgt_q  [DEPTH];

  logic [TAGW-1:0] head_q, tail_q;
  logic [TAGW:0]   count_q, count_d;
  logic            pend_q;

  logic            cm_valid_q, st_commit_q, flush_q;
  logic [4:0]      cm_rd_q;
  logic [XLEN-1:0] cm_val_q, flush_pc_q;
  logic [TAGW-1:0] cm_tag_q, st_tag_q;

  logic            act, clr;
  logic            do_alloc, do_commit;
  logic            wb0_hit, wb1_hit;
  logic            c_reg, c_st, c_fl;
  logic [XLEN-1:0] c_pc;

  assign alloc_ready = (count_q != FULL);
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  assign act       = rdy & ~pend_q;
  assign clr       = rdy & pend_q;
  assign do_alloc  = act & alloc_valid & alloc_ready;
  assign do_commit = act & (count_q != '0) & rdy_q[head_q];
  assign wb0_hit   = act & wb0_valid & vld_q[wb0_tag];
  assign wb1_hit   = act & wb1_valid & vld_q[wb1_tag];

  always_comb begin
    c_reg = 1'b0;
    c_st  = 1'b0;
    c_fl  = 1'b0;
    c_pc  = tgt_q[head_q];
    unique case (kind_q[head_q])
      2'd0: c_reg = 1'b1;
      2'd1: c_st  = 1'b1;
      2'd2: begin
        c_fl = tkn_q[head_q] != pred_q[head_q];
        c_pc = tkn_q[head_q] ? tgt_q[head_q] : alt_q[head_q];
      end
      2'd3: begin
        c_reg = 1'b1;
        c_fl  = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + (TAGW+1)'(1);
      2'b01:   count_d = count_q - (TAGW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  function automatic logic [XLEN:0] look(input logic [TAGW-1:0] t);
    logic [XLEN:0] r;
    r = '0;
    if (wb0_valid && wb0_tag == t)
      r = {1'b1, wb0_val};
    else if (wb1_valid && wb1_tag == t)
      r = {1'b1, wb1_val};
    else if (vld_q[t] && rdy_q[t])
      r = {1'b1, val_q[t]};
    return r;
  endfunction

  assign {q1_ready, q1_val} = look(q1_tag);
  assign {q2_ready, q2_val} = look(q2_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      rdy_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else if (clr) begin
      vld_q   <= '0;
      rdy_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else if (rdy) begin
      if (wb0_hit) rdy_q[wb0_tag] <= 1'b1;
      if (wb1_hit) rdy_q[wb1_tag] <= 1'b1;
      if (do_commit) begin
        vld_q[head_q] <= 1'b0;
        rdy_q[head_q] <= 1'b0;
        head_q        <= head_q + TAGW'(1);
      end
      if (do_alloc) begin
        vld_q[tail_q] <= 1'b1;
        rdy_q[tail_q] <= alloc_done;
        tail_q        <= tail_q + TAGW'(1);
      end
      count_q <= count_d;
      pend_q  <= do_commit & c_fl;
    end
  end

  // Payload RAM: no reset needed, valid/ready bits gate every use.
  always_ff @(posedge clk) begin
    if (wb1_hit) val_q[wb1_tag] <= wb1_val;
    if (wb0_hit) begin
      val_q[wb0_tag] <= wb0_val;
      tkn_q[wb0_tag] <= wb0_taken;
      tgt_q[wb0_tag] <= wb0_target;
    end
    if (do_alloc) begin
      kind_q[tail_q] <= alloc_kind;
      rd_q[tail_q]   <= alloc_rd;
      val_q[tail_q]  <= alloc_val;
      pred_q[tail_q] <= alloc_pred;
      alt_q[tail_q]  <= alloc_alt_pc;
      tkn_q[tail_q]  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_valid_q  <= 1'b0;
      st_commit_q <= 1'b0;
      flush_q     <= 1'b0;
      cm_rd_q     <= '0;
      cm_val_q    <= '0;
      cm_tag_q    <= '0;
      st_tag_q    <= '0;
      flush_pc_q  <= '0;
    end else begin
      cm_valid_q  <= do_commit & c_reg;
      st_commit_q <= do_commit & c_st;
      flush_q     <= do_commit & c_fl;
      if (do_commit && c_reg) begin
        cm_rd_q  <= rd_q[head_q];
        cm_val_q <= val_q[head_q];
        cm_tag_q <= head_q;
      end
      if (do_commit && c_st) st_tag_q <= head_q;
      if (do_commit && c_fl) flush_pc_q <= c_pc;
    end
  end

  assign cm_valid  = cm_valid_q;
  assign st_commit = st_commit_q;
  assign flush     = flush_q;
  assign cm_rd     = cm_rd_q;
  assign cm_val    = cm_val_q;
  assign cm_tag    = cm_tag_q;
  assign st_tag    = st_tag_q;
  assign flush_pc  = flush_pc_q;

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer, successor to the fixed 16-entry ROB. Sits between decode/dispatch and the register file / LSB.
- Allocates in program order and accepts out-of-order results from two writeback ports (ALU, LSB).
- Serves combinational operand lookups for two sources and retires one entry per cycle in order.
- New over the previous generation: configurable depth/width, explicit branch/JALR misprediction flush, store-commit handshake, occupancy count.

Parameters:
DEPTH, 16, number of entries; power of two, 4..64
XLEN, 32, data and PC width
TAGW, $clog2(DEPTH), entry tag width (derived; not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; low freezes all state
alloc_valid  in  1  dispatch presents an instruction
alloc_ready  out  1  entry available (count != DEPTH)
alloc_tag  out  TAGW  tag that the next allocation receives (= tail)
alloc_kind  in  2  0 reg-write, 1 store, 2 branch, 3 jalr
alloc_rd  in  5  destination register
alloc_done  in  1  result already known at dispatch (LUI/AUIPC/JAL/store)
alloc_val  in  XLEN  result value when alloc_done=1
alloc_pred  in  1  predicted taken (branch only)
alloc_alt_pc  in  XLEN  recovery PC if the prediction is wrong (branch only)
wb0_valid, wb0_tag, wb0_val  in  1/TAGW/XLEN  ALU writeback
wb0_taken, wb0_target  in  1/XLEN  branch outcome; JALR target
wb1_valid, wb1_tag, wb1_val  in  1/TAGW/XLEN  LSB load writeback
q1_tag, q2_tag  in  TAGW  operand lookup tags
q1_ready, q2_ready  out  1  value available (combinational)
q1_val, q2_val  out  XLEN  value (combinational)
cm_valid  out  1  register-write commit pulse
cm_rd  out  5  committed rd
cm_val  out  XLEN  committed value
cm_tag  out  TAGW  committed tag (regfile clears its rename only on match)
st_commit  out  1  pulse: store at head retired; LSB may write memory
st_tag  out  TAGW  tag of the retired store
flush  out  1  pulse: pipeline flush
flush_pc  out  XLEN  restart PC
count  out  TAGW+1  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): head=tail=0, count=0, all entry valid/ready bits 0; cm_valid=st_commit=flush=0; cm_rd=0, cm_val=0, cm_tag=0, st_tag=0, flush_pc=0. Entry payload RAM need not be reset.
- rdy=0: no state changes; pulse outputs (cm_valid, st_commit, flush) are driven 0 on the next edge; combinational outputs stay live.
- Allocate when alloc_valid & alloc_ready & rdy:
  - Entry[tail] gets valid=1, ready=alloc_done, kind, rd, val, pred, alt_pc.
  - tail wraps modulo DEPTH. alloc_ready depends on registered count only, so a commit in the same cycle does not enable an allocation.
- Writeback: on wbN_valid with entry valid, set ready=1 and store val.
  - wb0 on a branch stores taken; wb0 on a JALR stores target into the PC field.
  - Writeback to an invalid tag is ignored.
  - wb0 and wb1 to the same tag in one cycle: wb0 wins.
- Operand lookup, combinational, priority: wb0 match, then wb1 match, then entry ready. Otherwise qN_ready=0, qN_val=0.
- Commit: when count != 0 and entry[head] is ready (registered), retire the head, head+1 (wraps), count-1. Latency from writeback to commit is at least 1 cycle; there is no same-cycle bypass.
  - kind 0: cm_valid=1 with rd, val, tag.
  - kind 1: st_commit=1, st_tag=head.
  - kind 2, taken == pred: retire silently.
  - kind 2, taken != pred: flush=1; flush_pc = taken ? stored target : alt_pc (alt_pc holds the fall-through PC when pred=1).
  - kind 3: cm_valid=1 (rd = link value) and flush=1 with flush_pc = stored target.
- Flush: the cycle after a flushing commit is registered, all entries are invalidated and head=tail=count=0.
  - An allocation presented in that same edge is discarded.
  - Writebacks in the flush cycle are discarded.
- Simultaneous allocate and commit: count is unchanged.
- Full: allocation blocked while the head may still commit.
- Empty: no commit; pulse outputs are 0.

Test Plan:
- Reset then allocate 3 reg-write entries (rd=1,2,3), wb0 tag 1 val 0x22 -> no commit until tag0 is ready; wb0 tag0 val 0x11 -> cm_rd=1/0x11, then rd=2/0x22, each one cycle after ready.
- DEPTH=4: allocate 4 -> alloc_ready=0, count=4. Commit head and assert alloc_valid in the same cycle -> allocation rejected that cycle, accepted the next; tail wraps to 1.
- Branch pred=0, alt_pc=0x100, wb0 taken=1 target=0x200, plus two younger entries -> flush=1, flush_pc=0x200, count=0 next cycle, younger entries never commit.
- JALR rd=5 val 0x1C, wb0 target 0x400 -> cm_valid rd=5 0x1C and flush_pc=0x400 in the same cycle.
- q1_tag on a pending entry with wb1_valid to the same tag (val 0xABCD) -> q1_ready=1, q1_val=0xABCD combinationally; wb0 and wb1 to the same tag -> wb0 value stored.
- Drop rst_n mid-stream with count=3 -> count=0 and all pulses 0 immediately, no clock required. rdy=0 for 2 cycles -> count frozen, no commit.
